// File: rtl/hdc_frame_assembler_pkg.sv
// Shared types and constants for the HDC frame assembler slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Widths come from the shared const.vh. The fallbacks below apply only when
// that header has not been included ahead of this file.
`ifndef INPUT_CHANNELS
`define INPUT_CHANNELS 64
`endif
`ifndef RAW_WIDTH
`define RAW_WIDTH 15
`endif
`ifndef MODE_WIDTH
`define MODE_WIDTH 2
`endif
`ifndef LABEL_WIDTH
`define LABEL_WIDTH 5
`endif

package hdc_frame_assembler_pkg;

  localparam int MODE_W  = `MODE_WIDTH;
  localparam int LABEL_W = `LABEL_WIDTH;

  // COLLECT: gathering samples. HOLD: collect buffer full, waiting for the slot.
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } asmState_t;

  // Channel index width; a 1-channel frame still needs a 1-bit index.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hdc_frame_assembler_if.sv
// Sample-in / frame-out bus of the frame assembler.
// Latency: n/a (signal bundle only).
// Backpressure: SampleValid/SampleReady upstream, ValidOut/ReadyIn downstream.
//
// slave  : the assembler (takes samples, presents frames).
// master : the environment (drives samples, consumes frames).
interface hdc_frame_assembler_if #(
  parameter int CHANNELS = `INPUT_CHANNELS,
  parameter int SAMPLE_W = `RAW_WIDTH,
  parameter int LANE_W   = 16
);
  import hdc_frame_assembler_pkg::*;

  localparam int IDX_W = idxWidth(CHANNELS);

  logic                         SampleValid_SI;
  logic                         SampleReady_SO;
  logic [SAMPLE_W-1:0]          Sample_DI;
  logic                         SampleLast_SI;
  logic [MODE_W-1:0]            ModeIn_SI;
  logic [LABEL_W-1:0]           LabelIn_DI;
  logic [IDX_W-1:0]             ChannelIdx_DO;
  logic                         ValidOut_SO;
  logic                         ReadyIn_SI;
  logic [MODE_W-1:0]            ModeOut_SO;
  logic [LABEL_W-1:0]           LabelOut_DO;
  logic [CHANNELS*LANE_W-1:0]   Raw_DO;
  logic                         FrameError_SO;

  modport slave (
    input  SampleValid_SI, Sample_DI, SampleLast_SI, ModeIn_SI, LabelIn_DI, ReadyIn_SI,
    output SampleReady_SO, ChannelIdx_DO, ValidOut_SO, ModeOut_SO, LabelOut_DO, Raw_DO,
           FrameError_SO
  );

  modport master (
    output SampleValid_SI, Sample_DI, SampleLast_SI, ModeIn_SI, LabelIn_DI, ReadyIn_SI,
    input  SampleReady_SO, ChannelIdx_DO, ValidOut_SO, ModeOut_SO, LabelOut_DO, Raw_DO,
           FrameError_SO
  );

endinterface

// File: rtl/hdc_frame_slot.sv
// Output slot: one registered frame presented with valid/ready toward hdc_top.
// Latency: Load_SI on cycle t -> ValidOut_SO=1 on cycle t+1.
// Backpressure: contents held stable while ValidOut_SO=1 and ReadyIn_SI=0.
//
// Ports: Load_SI/Raw_DI/Mode_DI/Label_DI write the slot (only when Free_SO);
// Free_SO = slot empty or handshaking this cycle; ValidOut_SO, Raw_DO,
// Mode_DO, Label_DO are the registered frame outputs.
module hdc_frame_slot
  import hdc_frame_assembler_pkg::*;
#(
  parameter int RAW_W = 1024
) (
  input  logic               Clk_CI,
  input  logic               Reset_RI,
  input  logic               Load_SI,
  input  logic [RAW_W-1:0]   Raw_DI,
  input  logic [MODE_W-1:0]  Mode_DI,
  input  logic [LABEL_W-1:0] Label_DI,
  input  logic               ReadyIn_SI,
  output logic               Free_SO,
  output logic               ValidOut_SO,
  output logic [RAW_W-1:0]   Raw_DO,
  output logic [MODE_W-1:0]  Mode_DO,
  output logic [LABEL_W-1:0] Label_DO
);

  assign Free_SO = ~ValidOut_SO | ReadyIn_SI;

  always_ff @(posedge Clk_CI or negedge Reset_RI) begin
    if (!Reset_RI) begin
      ValidOut_SO <= 1'b0;
      Raw_DO      <= '0;
      Mode_DO     <= '0;
      Label_DO    <= '0;
    end else if (Load_SI) begin
      // A load in the handshake cycle keeps ValidOut_SO high with no bubble.
      ValidOut_SO <= 1'b1;
      Raw_DO      <= Raw_DI;
      Mode_DO     <= Mode_DI;
      Label_DO    <= Label_DI;
    end else if (ReadyIn_SI) begin
      ValidOut_SO <= 1'b0;
    end
  end

endmodule

// File: rtl/hdc_frame_assembler.sv
// Packs per-channel samples into one wide frame for hdc_top (collect buffer + output slot).
// Latency: last sample accepted on cycle t -> ValidOut_SO=1 on cycle t+1 when the slot is free.
// Backpressure: SampleReady_SO drops only while a complete frame waits behind an occupied slot.
//
// Ports: Clk_CI, Reset_RI (async, active-low) and the slave side of
// hdc_frame_assembler_if (sample input, frame output, ChannelIdx_DO, FrameError_SO).
module hdc_frame_assembler
  import hdc_frame_assembler_pkg::*;
#(
  parameter int CHANNELS = `INPUT_CHANNELS,
  parameter int SAMPLE_W = `RAW_WIDTH,
  parameter int LANE_W   = 16
) (
  input  logic                  Clk_CI,
  input  logic                  Reset_RI,
  hdc_frame_assembler_if.slave  Bus
);

  localparam int IDX_W = idxWidth(CHANNELS);
  localparam int RAW_W = CHANNELS * LANE_W;

  asmState_t          state;
  logic               sampleReady;
  logic [IDX_W-1:0]   chanIdx;
  logic               frameError;

  logic [RAW_W-1:0]   collectRaw,   collectRawNext;
  logic [MODE_W-1:0]  collectMode,  collectModeNext;
  logic [LABEL_W-1:0] collectLabel, collectLabelNext;

  logic accept, atLastIdx, complete, framingErr, slotFree, slotLoad;

  assign accept     = Bus.SampleValid_SI & sampleReady;
  assign atLastIdx  = (chanIdx == IDX_W'(CHANNELS - 1));
  assign complete   = accept & atLastIdx & Bus.SampleLast_SI;
  assign framingErr = accept & (Bus.SampleLast_SI != atLastIdx);

  // Collect buffer with this cycle's sample merged in. In HOLD nothing is
  // accepted, so this equals the held frame and serves as the slot load data
  // in both states.
  always_comb begin
    collectRawNext   = collectRaw;
    collectModeNext  = collectMode;
    collectLabelNext = collectLabel;
    if (accept) begin
      collectRawNext[int'(chanIdx)*LANE_W +: LANE_W] = LANE_W'(Bus.Sample_DI);
      if (chanIdx == '0) begin
        collectModeNext  = Bus.ModeIn_SI;
        collectLabelNext = Bus.LabelIn_DI;
      end
    end
  end

  assign slotLoad = (state == HOLD) ? slotFree : (complete & slotFree);

  always_ff @(posedge Clk_CI or negedge Reset_RI) begin
    if (!Reset_RI) begin
      state        <= COLLECT;
      sampleReady  <= 1'b1;
      chanIdx      <= '0;
      frameError   <= 1'b0;
      collectRaw   <= '0;
      collectMode  <= '0;
      collectLabel <= '0;
    end else begin
      collectRaw   <= collectRawNext;
      collectMode  <= collectModeNext;
      collectLabel <= collectLabelNext;
      // A framing error restarts at channel 0; stale lanes of the discarded
      // frame are overwritten before the next frame can complete.
      if (accept) begin
        chanIdx <= (framingErr | atLastIdx) ? '0 : chanIdx + IDX_W'(1);
      end
      if (framingErr) begin
        frameError <= 1'b1;
      end
      case (state)
        COLLECT: begin
          if (complete & ~slotFree) begin
            state       <= HOLD;
            sampleReady <= 1'b0;
          end
        end
        HOLD: begin
          if (slotFree) begin
            state       <= COLLECT;
            sampleReady <= 1'b1;
          end
        end
        default: begin
          state       <= COLLECT;
          sampleReady <= 1'b1;
        end
      endcase
    end
  end

  logic               slotValid;
  logic [RAW_W-1:0]   slotRaw;
  logic [MODE_W-1:0]  slotMode;
  logic [LABEL_W-1:0] slotLabel;

  hdc_frame_slot #(
    .RAW_W (RAW_W)
  ) uSlot (
    .Clk_CI      (Clk_CI),
    .Reset_RI    (Reset_RI),
    .Load_SI     (slotLoad),
    .Raw_DI      (collectRawNext),
    .Mode_DI     (collectModeNext),
    .Label_DI    (collectLabelNext),
    .ReadyIn_SI  (Bus.ReadyIn_SI),
    .Free_SO     (slotFree),
    .ValidOut_SO (slotValid),
    .Raw_DO      (slotRaw),
    .Mode_DO     (slotMode),
    .Label_DO    (slotLabel)
  );

  assign Bus.SampleReady_SO = sampleReady;
  assign Bus.ChannelIdx_DO  = chanIdx;
  assign Bus.FrameError_SO  = frameError;
  assign Bus.ValidOut_SO    = slotValid;
  assign Bus.Raw_DO         = slotRaw;
  assign Bus.ModeOut_SO     = slotMode;
  assign Bus.LabelOut_DO    = slotLabel;

endmodule

// File: tb/tb_hdc_frame_assembler.sv
// Self-checking bench for hdc_frame_assembler: directed scenarios plus a
// randomized stall run, all checked against a frame-level scoreboard.
module tb_hdc_frame_assembler;
  import hdc_frame_assembler_pkg::*;

  localparam int CHANNELS = `INPUT_CHANNELS;
  localparam int SAMPLE_W = `RAW_WIDTH;
  localparam int LANE_W   = 16;

  typedef struct packed {
    logic [CHANNELS-1:0][SAMPLE_W-1:0] lane;
    logic [MODE_W-1:0]                 mode;
    logic [LABEL_W-1:0]                label;
  } frame_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  hdc_frame_assembler_if #(.CHANNELS(CHANNELS), .SAMPLE_W(SAMPLE_W), .LANE_W(LANE_W)) bus();

  hdc_frame_assembler #(
    .CHANNELS (CHANNELS),
    .SAMPLE_W (SAMPLE_W),
    .LANE_W   (LANE_W)
  ) dut (
    .Clk_CI   (clk),
    .Reset_RI (rstN),
    .Bus      (bus)
  );

  int     nChecks = 0;
  int     nFails  = 0;
  frame_t expQ[$];
  int     framesIn  = 0;
  int     framesOut = 0;
  int     readyPolicy = 3;   // 0 low, 1 high, 2 random, 3 follow manualReady
  logic   manualReady = 1'b0;

  task automatic assertEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // Downstream consumer: drives ReadyIn_SI and checks every handshaken frame.
  initial begin : consumer
    frame_t f;
    bus.ReadyIn_SI = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (readyPolicy)
        0:       bus.ReadyIn_SI = 1'b0;
        1:       bus.ReadyIn_SI = 1'b1;
        2:       bus.ReadyIn_SI = ($urandom_range(0, 2) != 0);
        default: bus.ReadyIn_SI = manualReady;
      endcase
      #1;
      if (rstN && bus.ValidOut_SO && bus.ReadyIn_SI) begin
        assertEq("sb_has_frame", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          f = expQ.pop_front();
          framesOut++;
          for (int k = 0; k < CHANNELS; k++)
            assertEq($sformatf("lane%0d", k), 32'(bus.Raw_DO[k*LANE_W +: LANE_W]), 32'(f.lane[k]));
          assertEq("mode_out", 32'(bus.ModeOut_SO), 32'(f.mode));
          assertEq("label_out", 32'(bus.LabelOut_DO), 32'(f.label));
        end
      end
    end
  end

  // Presents one sample for channel k; returns at the negedge after it was accepted.
  task automatic sendSample(input int k, input logic [SAMPLE_W-1:0] d, input logic last,
                            input logic [MODE_W-1:0] m, input logic [LABEL_W-1:0] l,
                            input bit gaps, input bit raiseReady, output bit ok);
    if (gaps) begin
      bus.SampleValid_SI = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.SampleValid_SI = 1'b1;
    bus.Sample_DI      = d;
    bus.SampleLast_SI  = last;
    bus.ModeIn_SI      = m;
    bus.LabelIn_DI     = l;
    if (raiseReady) manualReady = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 2000 && !ok; w++) begin
      if (bus.SampleReady_SO) begin
        assertEq("chan_idx", 32'(bus.ChannelIdx_DO), k);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    bus.SampleValid_SI = 1'b0;
    bus.SampleLast_SI  = 1'b0;
    if (!ok) assertEq("sample_accept_timeout", 32'(ok), 32'd1);
  endtask

  // Sends nSamples samples of a frame. errIdx >= 0 inverts the last flag at that
  // index and ends the frame there (it must be discarded). Only complete frames
  // go to the scoreboard.
  task automatic sendFrame(input int nSamples, input int errIdx, input bit gaps, input bit ramp,
                           input bit readyAtLast, input logic [MODE_W-1:0] m,
                           input logic [LABEL_W-1:0] l);
    frame_t              f;
    bit                  ok;
    logic                last;
    logic [SAMPLE_W-1:0] d;
    f = '0;
    f.mode  = m;
    f.label = l;
    for (int k = 0; k < nSamples; k++) begin
      d = ramp ? SAMPLE_W'(k) : SAMPLE_W'($urandom);
      f.lane[k] = d;
      last = (k == errIdx) ? (k != CHANNELS - 1) : (k == CHANNELS - 1);
      // Mode/label on channels other than 0 are noise the assembler must ignore.
      sendSample(k, d, last,
                 (k == 0) ? m : MODE_W'($urandom), (k == 0) ? l : LABEL_W'($urandom),
                 gaps, readyAtLast && (k == CHANNELS - 1), ok);
      if (!ok || k == errIdx) return;
      if (k == CHANNELS - 1) begin
        expQ.push_back(f);
        framesIn++;
      end
    end
  endtask

  task automatic waitDrain(input string tag);
    for (int w = 0; w < 5000 && expQ.size() > 0; w++) @(negedge clk);
    assertEq(tag, 32'(expQ.size()), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    assertEq({tag, "_valid"}, 32'(bus.ValidOut_SO), 32'd0);
    assertEq({tag, "_raw"},   32'(|bus.Raw_DO), 32'd0);
    assertEq({tag, "_mode"},  32'(bus.ModeOut_SO), 32'd0);
    assertEq({tag, "_label"}, 32'(bus.LabelOut_DO), 32'd0);
    assertEq({tag, "_idx"},   32'(bus.ChannelIdx_DO), 32'd0);
    assertEq({tag, "_err"},   32'(bus.FrameError_SO), 32'd0);
    assertEq({tag, "_ready"}, 32'(bus.SampleReady_SO), 32'd1);
  endtask

  initial begin : main
    int e, outMark, inMark;
    bus.SampleValid_SI = 1'b0;
    bus.Sample_DI      = '0;
    bus.SampleLast_SI  = 1'b0;
    bus.ModeIn_SI      = '0;
    bus.LabelIn_DI     = '0;
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("rst");
    rstN = 1'b1;
    @(negedge clk);
    assertEq("post_rst_ready", 32'(bus.SampleReady_SO), 32'd1);

    // Ramp frame, mode 1 / label 3, consumer always ready.
    readyPolicy = 3;
    manualReady = 1'b1;
    sendFrame(CHANNELS, -1, 0, 1, 0, MODE_W'(1), LABEL_W'(3));
    assertEq("ramp_valid_next_cycle", 32'(bus.ValidOut_SO), 32'd1);
    @(negedge clk);
    assertEq("ramp_valid_drop", 32'(bus.ValidOut_SO), 32'd0);
    assertEq("ramp_consumed", 32'(framesOut), 32'd1);

    // Consumer stalled: frame 1 in slot, frame 2 held, input blocked.
    readyPolicy = 0;
    sendFrame(CHANNELS, -1, 0, 0, 0, MODE_W'($urandom), LABEL_W'($urandom));
    sendFrame(CHANNELS, -1, 0, 0, 0, MODE_W'($urandom), LABEL_W'($urandom));
    repeat (3) @(negedge clk);
    assertEq("hold_sample_ready", 32'(bus.SampleReady_SO), 32'd0);
    assertEq("hold_slot_valid", 32'(bus.ValidOut_SO), 32'd1);
    assertEq("hold_pending", 32'(expQ.size()), 32'd2);
    readyPolicy = 1;
    sendFrame(CHANNELS, -1, 0, 0, 0, MODE_W'($urandom), LABEL_W'($urandom));
    waitDrain("hold_drain");
    assertEq("hold_frames_out", 32'(framesOut), 32'd4);

    // Last sample accepted in the slot-handshake cycle: no bubble, no HOLD.
    readyPolicy = 3;
    manualReady = 1'b0;
    sendFrame(CHANNELS, -1, 0, 0, 0, MODE_W'($urandom), LABEL_W'($urandom));
    sendFrame(CHANNELS, -1, 0, 0, 1, MODE_W'($urandom), LABEL_W'($urandom));
    assertEq("swap_valid", 32'(bus.ValidOut_SO), 32'd1);
    assertEq("swap_no_hold", 32'(bus.SampleReady_SO), 32'd1);
    assertEq("swap_pending", 32'(expQ.size()), 32'd1);
    waitDrain("swap_drain");

    // Framing errors: early last at 10, then missing last at the final channel.
    readyPolicy = 1;
    outMark = framesOut;
    sendFrame(CHANNELS, 10, 0, 0, 0, MODE_W'($urandom), LABEL_W'($urandom));
    assertEq("ferr_flag", 32'(bus.FrameError_SO), 32'd1);
    assertEq("ferr_idx", 32'(bus.ChannelIdx_DO), 32'd0);
    sendFrame(CHANNELS, CHANNELS - 1, 0, 0, 0, MODE_W'($urandom), LABEL_W'($urandom));
    assertEq("ferr_nolast_idx", 32'(bus.ChannelIdx_DO), 32'd0);
    repeat (5) @(negedge clk);
    assertEq("ferr_nothing_out", 32'(framesOut), 32'(outMark));
    sendFrame(CHANNELS, -1, 0, 0, 0, MODE_W'($urandom), LABEL_W'($urandom));
    waitDrain("ferr_drain");
    assertEq("ferr_good_frame_out", 32'(framesOut), 32'(outMark + 1));
    assertEq("ferr_sticky", 32'(bus.FrameError_SO), 32'd1);

    // Reset mid-frame with a frame pending in the slot.
    readyPolicy = 3;
    manualReady = 1'b0;
    sendFrame(CHANNELS, -1, 0, 0, 0, MODE_W'($urandom), LABEL_W'($urandom));
    sendFrame(30, -1, 0, 0, 0, MODE_W'($urandom), LABEL_W'($urandom));
    assertEq("mid_idx", 32'(bus.ChannelIdx_DO), 32'd30);
    rstN = 1'b0;
    #1;
    checkResetOutputs("midrst");
    expQ.delete();
    @(negedge clk);
    rstN = 1'b1;
    outMark = framesOut;
    manualReady = 1'b1;
    repeat (20) @(negedge clk);
    assertEq("midrst_no_stale", 32'(bus.ValidOut_SO), 32'd0);
    assertEq("midrst_nothing_out", 32'(framesOut), 32'(outMark));
    sendFrame(CHANNELS, -1, 0, 0, 0, MODE_W'($urandom), LABEL_W'($urandom));
    waitDrain("midrst_drain");

    // 100 frames with random upstream gaps, downstream stalls and occasional errors.
    readyPolicy = 2;
    outMark = framesOut;
    inMark  = framesIn;
    for (int i = 0; i < 100; i++) begin
      e = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, CHANNELS - 1)) : -1;
      sendFrame(CHANNELS, e, 1, 0, 0, MODE_W'($urandom), LABEL_W'($urandom));
    end
    waitDrain("rand_drain");
    assertEq("rand_in_eq_out", 32'(framesOut - outMark), 32'(framesIn - inMark));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/hdc_frame_assembler.md
HDC_FRAME_ASSEMBLER -- requirements
Module: hdc_frame_assembler

Interface
REQ-001 SHALL have parameter CHANNELS, default `INPUT_CHANNELS (64): number of channels per frame.
REQ-002 SHALL have parameter SAMPLE_W, default `RAW_WIDTH (15): width of one channel sample.
REQ-003 SHALL have parameter LANE_W, default 16: per-channel lane width in Raw_DO.
REQ-004 SHALL have one clock; reset is asynchronous and active-low, with ports as follows.
REQ-005 Clk_CI  in  1  sole clock, rising edge.
REQ-006 Reset_RI  in  1  asynchronous, active-low reset.
REQ-007 SampleValid_SI  in  1  upstream sample valid.
REQ-008 SampleReady_SO  out  1  assembler accepts a sample.
REQ-009 Sample_DI  in  SAMPLE_W  sample for channel ChannelIdx_DO.
REQ-010 SampleLast_SI  in  1  upstream marks the final sample of a frame.
REQ-011 ModeIn_SI  in  `MODE_WIDTH  frame mode, captured with channel 0.
REQ-012 LabelIn_DI  in  `LABEL_WIDTH  frame label, captured with channel 0.
REQ-013 ChannelIdx_DO  out  clog2(CHANNELS)  index of the next expected channel.
REQ-014 ValidOut_SO  out  1  assembled frame valid toward hdc_top.
REQ-015 ReadyIn_SI  in  1  hdc_top ready (its ReadyOut_SO).
REQ-016 ModeOut_SO  out  `MODE_WIDTH  mode of the presented frame.
REQ-017 LabelOut_DO  out  `LABEL_WIDTH  label of the presented frame.
REQ-018 Raw_DO  out  CHANNELS*LANE_W  frame data for hdc_top Raw_DI.
REQ-019 FrameError_SO  out  1  sticky framing-error flag.

Function
REQ-020 Sample accepted iff SampleValid_SI & SampleReady_SO on a rising edge.
REQ-021 Accepted sample k SHALL land in Raw[k*LANE_W+SAMPLE_W-1 : k*LANE_W]; lane bits above SAMPLE_W are 0.
REQ-022 ModeIn_SI/LabelIn_DI SHALL be captured only on acceptance of channel 0; ignored otherwise.
REQ-023 ChannelIdx_DO SHALL increment per accepted sample and wrap CHANNELS-1 -> 0.
REQ-024 Storage SHALL be double-buffered: one collect buffer plus one output slot.
REQ-025 FSM states: COLLECT (SampleReady_SO=1), HOLD (collect buffer complete, output slot occupied; SampleReady_SO=0).
REQ-026 Frame completion = acceptance at index CHANNELS-1 with SampleLast_SI=1.
REQ-027 On completion with the slot empty, or the slot handshaking (ValidOut_SO & ReadyIn_SI) in the same cycle: frame moves to the slot; ValidOut_SO=1 on the next cycle; stay in COLLECT.
REQ-028 On completion with the slot occupied and not handshaking: enter HOLD.
REQ-029 HOLD -> COLLECT on the cycle of the slot handshake; the held frame enters the slot and ValidOut_SO stays 1 on the next cycle.
REQ-030 Latency: the last sample accepted on cycle t gives ValidOut_SO=1 on cycle t+1 (slot free); channel 0 of the next frame is acceptable on cycle t+1.
REQ-031 ValidOut_SO, ModeOut_SO, LabelOut_DO and Raw_DO SHALL be registered and stable while ValidOut_SO=1 and ReadyIn_SI=0.
REQ-032 ValidOut_SO SHALL deassert after a handshake unless a new frame loads in the same cycle.
REQ-033 Framing error (SampleLast_SI=1 at index != CHANNELS-1, or SampleLast_SI=0 at index CHANNELS-1): discard the partial frame, set ChannelIdx_DO to 0, set FrameError_SO; the output slot is unaffected.
REQ-034 FrameError_SO SHALL be cleared only by reset.

Reset
REQ-035 Reset_RI=0 SHALL asynchronously force: FSM=COLLECT, ChannelIdx_DO=0, ValidOut_SO=0, Raw_DO=0, ModeOut_SO=0, LabelOut_DO=0, FrameError_SO=0, collect buffer cleared.
REQ-036 SampleReady_SO SHALL be 1 in and immediately after reset.
REQ-037 Reset mid-frame or mid-handshake SHALL drop all buffered frames; no partial frame is emitted after reset.

Structure
REQ-038 MODE_WIDTH, LABEL_WIDTH, RAW_WIDTH and INPUT_CHANNELS SHALL come from the shared const.vh; no local redefinition.
REQ-039 The output slot (registers plus valid/ready logic) SHALL be one sub-module, hdc_frame_slot.

Verification
REQ-040 64 samples, sample k = k, mode=1, label=3, ReadyIn_SI=1 -> one frame; lane k = k with bit 15 = 0; mode 1, label 3; ValidOut_SO 1 cycle after the 64th accept.
REQ-041 ReadyIn_SI=0, three back-to-back frames -> frame 1 in the slot, frame 2 in HOLD, SampleReady_SO=0; raising ReadyIn_SI -> frames 1 and 2 emitted in order, then frame 3.
REQ-042 Last sample accepted in the same cycle as the slot handshake -> new frame valid next cycle with no bubble, no HOLD entry.
REQ-043 SampleLast_SI=1 at index 10 -> FrameError_SO=1, ChannelIdx_DO=0, partial frame never emitted; the next correct frame is emitted normally.
REQ-044 Reset_RI pulsed low at index 30 with a frame pending in the slot -> all outputs at reset values, no stale frame afterwards.
REQ-045 Random SampleValid_SI/ReadyIn_SI stalls over 100 frames -> output matches the scoreboard; no frame lost or duplicated.
